// File: rtl/cphy_rx_pkg.sv
// Shared types and constants for the C-PHY RX symbol demapper slice.
package cphy_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        DATA
    } demap_state_t;

    localparam logic [2:0] SYM_PRE  = 3'd3;
    localparam logic [2:0] SYM_SYNC = 3'd4;

    localparam int unsigned SYMS_PER_WORD = 7;
    localparam logic [16:0] WORD_LIMIT    = 17'd65536;

    // Sync word in arrival order; index 0 is the first symbol received.
    localparam logic [0:6][2:0] SYNC_WORD = {3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3};

    // Positions 0 and 1 are consumed by the preamble state on the first 4.
    localparam logic [2:0] SYNC_FIRST_IDX = 3'd2;
    localparam logic [2:0] SYNC_LAST_IDX  = 3'd6;

endpackage

// File: rtl/cphy_sym_sync_fsm.sv
// Preamble and sync-word detector; pulses sync_done on the edge that
// samples the final symbol of the sync word.
module cphy_sym_sync_fsm
    import cphy_rx_pkg::*;
#(
    parameter int unsigned PREAMBLE_MIN = 7
) (
    input  logic       RxSymbolClkHS,
    input  logic       reset,
    input  logic       SymValid,
    input  logic [2:0] Sym,
    input  logic       hold,
    output logic       sync_done
);

    localparam int unsigned   PW      = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PW-1:0] PRE_SAT = PW'(PREAMBLE_MIN);

    demap_state_t  state_q, state_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [2:0]    sync_idx_q, sync_idx_d;

    // State, preamble counter and sync position registers.
    always_ff @(posedge RxSymbolClkHS) begin
        if (!reset) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            sync_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            sync_idx_q <= sync_idx_d;
        end
    end

    // Next-state logic; held in IDLE while the parent is in a data burst.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        sync_idx_d = sync_idx_q;
        sync_done  = 1'b0;
        if (!SymValid || hold) begin
            state_d   = IDLE;
            pre_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Sym == SYM_PRE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = PW'(1);
                    end
                end
                PREAMBLE: begin
                    if (Sym == SYM_PRE) begin
                        if (pre_cnt_q < PRE_SAT) begin
                            pre_cnt_d = pre_cnt_q + PW'(1);
                        end
                    end else if (Sym == SYM_SYNC && pre_cnt_q >= PRE_SAT) begin
                        state_d    = SYNC;
                        sync_idx_d = SYNC_FIRST_IDX;
                    end else begin
                        state_d   = IDLE;
                        pre_cnt_d = '0;
                    end
                end
                SYNC: begin
                    if (Sym == SYNC_WORD[sync_idx_q]) begin
                        if (sync_idx_q == SYNC_LAST_IDX) begin
                            sync_done  = 1'b1;
                            state_d    = IDLE;
                            sync_idx_d = '0;
                            pre_cnt_d  = '0;
                        end else begin
                            sync_idx_d = sync_idx_q + 3'd1;
                        end
                    end else if (Sym == SYM_PRE) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = PW'(1);
                    end else begin
                        state_d   = IDLE;
                        pre_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pre_cnt_d = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cphy_sym_demapper.sv
// C-PHY RX symbol demapper: finds preamble/sync, then converts each group
// of seven base-5 symbols (first symbol most significant) to a 16-bit word.
module cphy_sym_demapper
    import cphy_rx_pkg::*;
#(
    parameter int unsigned PREAMBLE_MIN = 7,
    parameter int unsigned WCNT_W       = 16
) (
    input  logic              RxSymbolClkHS,
    input  logic              reset,
    input  logic              SymValid,
    input  logic [2:0]        Sym,
    output logic [15:0]       Word,
    output logic              WordValid,
    output logic              WordErr,
    output logic              CodeErr,
    output logic              SyncDet,
    output logic [WCNT_W-1:0] WordCnt,
    output logic              InBurst
);

    localparam logic [2:0] LAST_SYM = 3'(SYMS_PER_WORD - 1);

    logic        sync_done;
    logic [2:0]  sym_cnt_q;
    logic [16:0] acc_q;
    logic [16:0] acc_next;

    // InBurst doubles as the DATA-state flag; the detector idles meanwhile.
    cphy_sym_sync_fsm #(
        .PREAMBLE_MIN(PREAMBLE_MIN)
    ) u_sync (
        .RxSymbolClkHS(RxSymbolClkHS),
        .reset        (reset),
        .SymValid     (SymValid),
        .Sym          (Sym),
        .hold         (InBurst),
        .sync_done    (sync_done)
    );

    // Base-5 multiply-add of the incoming symbol onto the partial group.
    always_comb begin
        acc_next = acc_q * 17'd5 + {14'd0, Sym};
    end

    // Data-burst state, accumulator, word output and single-cycle pulses.
    always_ff @(posedge RxSymbolClkHS) begin
        if (!reset) begin
            Word      <= '0;
            WordValid <= 1'b0;
            WordErr   <= 1'b0;
            CodeErr   <= 1'b0;
            SyncDet   <= 1'b0;
            WordCnt   <= '0;
            InBurst   <= 1'b0;
            sym_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            WordValid <= 1'b0;
            WordErr   <= 1'b0;
            CodeErr   <= 1'b0;
            SyncDet   <= 1'b0;
            if (!SymValid) begin
                InBurst   <= 1'b0;
                sym_cnt_q <= '0;
                acc_q     <= '0;
                WordCnt   <= '0;
            end else if (InBurst) begin
                if (Sym > SYM_SYNC) begin
                    CodeErr   <= 1'b1;
                    InBurst   <= 1'b0;
                    sym_cnt_q <= '0;
                    acc_q     <= '0;
                end else if (sym_cnt_q == LAST_SYM) begin
                    if (acc_next < WORD_LIMIT) begin
                        Word      <= acc_next[15:0];
                        WordValid <= 1'b1;
                        if (WordCnt != '1) begin
                            WordCnt <= WordCnt + WCNT_W'(1);
                        end
                    end else begin
                        WordErr <= 1'b1;
                    end
                    sym_cnt_q <= '0;
                    acc_q     <= '0;
                end else begin
                    acc_q     <= acc_next;
                    sym_cnt_q <= sym_cnt_q + 3'd1;
                end
            end else if (sync_done) begin
                InBurst   <= 1'b1;
                SyncDet   <= 1'b1;
                sym_cnt_q <= '0;
                acc_q     <= '0;
                WordCnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cphy_sym_demapper.sv
// Scoreboard bench for cphy_sym_demapper: a symbol-stream model predicts
// each output pulse and the cycle it should appear in.
module tb_cphy_sym_demapper;

    localparam int PRE_MIN = 7;
    localparam int K_SYNC  = 1;
    localparam int K_WORD  = 2;
    localparam int K_WERR  = 3;
    localparam int K_CODE  = 4;

    typedef struct {
        int     kind;
        int     word;
        int     cnt;
        int     inb;
        longint tag;
    } ev_t;

    logic        RxSymbolClkHS = 1'b0;
    logic        reset;
    logic        SymValid;
    logic [2:0]  Sym;
    logic [15:0] Word;
    logic        WordValid;
    logic        WordErr;
    logic        CodeErr;
    logic        SyncDet;
    logic [15:0] WordCnt;
    logic        InBurst;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc   = 0;

    ev_t exp_q[$];
    int  hist[$];
    int  grp[$];
    bit  m_data = 0;
    int  m_word = 0;
    int  m_cnt  = 0;

    cphy_sym_demapper #(
        .PREAMBLE_MIN(PRE_MIN),
        .WCNT_W      (16)
    ) dut (
        .RxSymbolClkHS(RxSymbolClkHS),
        .reset        (reset),
        .SymValid     (SymValid),
        .Sym          (Sym),
        .Word         (Word),
        .WordValid    (WordValid),
        .WordErr      (WordErr),
        .CodeErr      (CodeErr),
        .SyncDet      (SyncDet),
        .WordCnt      (WordCnt),
        .InBurst      (InBurst)
    );

    always #5 RxSymbolClkHS = ~RxSymbolClkHS;

    always @(posedge RxSymbolClkHS) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pow5(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 5;
        return p;
    endfunction

    // Reference model: consumes one sampled (SymValid, Sym) pair.
    task automatic model_step(input bit v, input int s);
        ev_t e;
        bit  hit;
        int  val;
        e.tag = cyc + 1;
        if (!v) begin
            hist.delete();
            grp.delete();
            m_data = 0;
            m_cnt  = 0;
            return;
        end
        if (m_data) begin
            if (s >= 5) begin
                e.kind = K_CODE; e.word = m_word; e.cnt = m_cnt; e.inb = 0;
                exp_q.push_back(e);
                m_data = 0;
                grp.delete();
                hist.delete();
            end else begin
                grp.push_back(s);
                if (grp.size() == 7) begin
                    val = 0;
                    for (int i = 0; i < 7; i++) val += grp[i] * pow5(6 - i);
                    if (val < 65536) begin
                        m_word = val;
                        if (m_cnt < 65535) m_cnt++;
                        e.kind = K_WORD;
                    end else begin
                        e.kind = K_WERR;
                    end
                    e.word = m_word; e.cnt = m_cnt; e.inb = 1;
                    exp_q.push_back(e);
                    grp.delete();
                end
            end
        end else begin
            hist.push_back(s);
            if (hist.size() > 13) void'(hist.pop_front());
            hit = (hist.size() == 13);
            for (int i = 0; i < 13 && hit; i++) begin
                if (i < 7 || i == 12) hit = (hist[i] == 3);
                else                  hit = (hist[i] == 4);
            end
            if (hit) begin
                m_data = 1;
                m_cnt  = 0;
                grp.delete();
                hist.delete();
                e.kind = K_SYNC; e.word = m_word; e.cnt = 0; e.inb = 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step(input bit v, input int s);
        @(negedge RxSymbolClkHS);
        reset    = 1'b1;
        SymValid = v;
        Sym      = 3'(s);
        model_step(v, s);
    endtask

    task automatic settle();
        @(posedge RxSymbolClkHS);
        #1;
    endtask

    task automatic check_reset_values(input string tagname);
        chk({tagname, "_word"},  Word, 0);
        chk({tagname, "_wv"},    WordValid, 0);
        chk({tagname, "_we"},    WordErr, 0);
        chk({tagname, "_ce"},    CodeErr, 0);
        chk({tagname, "_sd"},    SyncDet, 0);
        chk({tagname, "_wcnt"},  WordCnt, 0);
        chk({tagname, "_inb"},   InBurst, 0);
    endtask

    task automatic do_reset();
        @(negedge RxSymbolClkHS);
        reset    = 1'b0;
        SymValid = 1'b1;
        Sym      = 3'($urandom_range(0, 4));
        hist.delete();
        grp.delete();
        m_data = 0;
        m_cnt  = 0;
        m_word = 0;
        settle();
        check_reset_values("rst");
    endtask

    task automatic pre(input int n);
        repeat (n) step(1, 3);
    endtask

    task automatic sync_tail();
        repeat (5) step(1, 4);
        step(1, 3);
    endtask

    // Sends the seven base-5 digits of w, most significant first.
    task automatic group(input int w);
        for (int i = 6; i >= 0; i--) step(1, (w / pow5(i)) % 5);
    endtask

    task automatic rand_group();
        for (int i = 0; i < 7; i++) begin
            if ($urandom_range(0, 49) == 0) step(1, $urandom_range(5, 7));
            else                            step(1, $urandom_range(0, 4));
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses an output.
    always begin
        int  np;
        int  kind;
        ev_t e;
        @(negedge RxSymbolClkHS);
        while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            e = exp_q.pop_front();
            chk("missed_event", 0, e.kind);
        end
        np   = int'(SyncDet) + int'(WordValid) + int'(WordErr) + int'(CodeErr);
        kind = SyncDet ? K_SYNC : WordValid ? K_WORD : WordErr ? K_WERR : CodeErr ? K_CODE : 0;
        if (np > 1) chk("pulse_exclusive", np, 1);
        if (np > 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", kind, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_cycle", cyc, e.tag);
                chk("ev_kind", kind, e.kind);
                chk("ev_word", Word, e.word);
                chk("ev_wcnt", WordCnt, e.cnt);
                chk("ev_inburst", InBurst, e.inb);
            end
        end
    end

    initial begin
        int r;
        reset    = 1'b0;
        SymValid = 1'b0;
        Sym      = 3'd0;
        repeat (3) @(negedge RxSymbolClkHS);
        settle();
        check_reset_values("init");

        // Sync then word 0x0001, 0xFFFF, 0x3D09, then an overflow group.
        step(0, 0);
        pre(7);
        sync_tail();
        settle();
        chk("inburst_after_sync", InBurst, 1);
        group(1);
        settle();
        chk("wcnt_first", WordCnt, 1);
        chk("word_first", Word, 16'h0001);
        group(65535);
        group(15625);
        settle();
        chk("wcnt_two", WordCnt, 3);
        chk("word_3d09", Word, 16'h3D09);
        group(78124);
        settle();
        chk("werr_word_held", Word, 16'h3D09);
        chk("werr_wcnt_held", WordCnt, 3);

        // Short preamble does not sync; full preamble does.
        step(0, 0);
        pre(5);
        sync_tail();
        settle();
        chk("short_pre_no_burst", InBurst, 0);
        pre(7);
        sync_tail();
        settle();
        chk("full_pre_burst", InBurst, 1);

        // Broken sync words.
        step(0, 0);
        pre(7);
        step(1, 4); step(1, 4); step(1, 2);
        settle();
        chk("sync_442_idle", InBurst, 0);
        pre(7);
        step(1, 4); step(1, 4); step(1, 3);
        pre(5);
        sync_tail();
        settle();
        chk("restart_short", InBurst, 0);
        step(0, 0);
        pre(7);
        step(1, 4); step(1, 4); step(1, 3);
        pre(6);
        sync_tail();
        settle();
        chk("restart_full", InBurst, 1);

        // Mid-group disruptions.
        step(1, 2); step(1, 1); step(1, 0);
        step(0, 0);
        settle();
        chk("drop_inburst", InBurst, 0);
        chk("drop_wcnt", WordCnt, 0);
        step(1, 4); step(1, 4); step(1, 4); step(1, 4);
        pre(7);
        sync_tail();
        step(1, 1); step(1, 1); step(1, 1);
        step(1, 6);
        settle();
        chk("code_inburst", InBurst, 0);
        step(0, 0);
        pre(7);
        sync_tail();
        step(1, 3); step(1, 3); step(1, 3);
        do_reset();

        // Randomized bursts.
        for (int b = 0; b < 250; b++) begin
            repeat ($urandom_range(0, 3)) step(1, $urandom_range(0, 7));
            pre($urandom_range(4, 10));
            if ($urandom_range(0, 4) != 0) sync_tail();
            else repeat (6) step(1, $urandom_range(2, 4));
            repeat ($urandom_range(0, 4)) rand_group();
            repeat ($urandom_range(0, 6)) step(1, $urandom_range(0, 4));
            r = $urandom_range(0, 9);
            if (r < 3)       repeat ($urandom_range(1, 3)) step(0, $urandom_range(0, 7));
            else if (r == 3) do_reset();
        end

        repeat (4) step(0, 0);
        settle();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cphy_sym_demapper.md
Name: cphy_sym_demapper

Overview:
- Sits directly downstream of the C-PHY RX symbol decoder and consumes its 3-bit `Sym` stream, one symbol per `RxSymbolClkHS` edge.
- Detects the preamble (run of symbol 3) and the sync word 3,4,4,4,4,4,3.
- After sync, groups data symbols seven at a time and demaps each group to a 16-bit word. The demap is the base-5 value of the group, first-received symbol most significant.
- Feeds the lane-level byte/packet assembly stage.

Parameters:
- PREAMBLE_MIN, 7: minimum count of consecutive 3 symbols, including the first 3 of the sync word, before a 4 is accepted as sync.
- WCNT_W, 16: width of the per-burst word counter.

Ports:
- RxSymbolClkHS  input  1  symbol clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- SymValid  input  1  high while the upstream decoder is enabled and `Sym` is meaningful.
- Sym  input  3  decoded symbol, legal values 0..4.
- Word  output  16  demapped data word.
- WordValid  output  1  one-cycle pulse; `Word` is valid.
- WordErr  output  1  one-cycle pulse; group value ≥ 65536, word dropped.
- CodeErr  output  1  one-cycle pulse; illegal symbol (5..7) in DATA.
- SyncDet  output  1  one-cycle pulse on sync-word completion.
- WordCnt  output  WCNT_W  words delivered since sync; saturates at all-ones.
- InBurst  output  1  high while in DATA state.

Behaviour:
- One clock domain: `RxSymbolClkHS`. Reset is synchronous and active-low (`reset`); all registers update on the rising edge only.
- Reset values: `Word`=0, `WordValid`=0, `WordErr`=0, `CodeErr`=0, `SyncDet`=0, `WordCnt`=0, `InBurst`=0, state=IDLE, PreCnt=0, SyncIdx=0, SymCnt=0, Acc=0.
- Reset asserted mid-burst forces reset values at the next edge; no partial word is emitted.
- `SymValid`=0 at an edge forces state IDLE and clears PreCnt, SymCnt, Acc and `WordCnt`. All pulse outputs are 0 that cycle and `Word` holds its value.
- Every non-IDLE transition below is evaluated only when `SymValid`=1.
- States are IDLE, PREAMBLE, SYNC and DATA.
- IDLE:
  - `Sym`=3 → PREAMBLE, PreCnt=1.
  - Any other symbol → stay in IDLE.
- PREAMBLE:
  - `Sym`=3 → PreCnt+1, saturating at PREAMBLE_MIN.
  - `Sym`=4 and PreCnt ≥ PREAMBLE_MIN → SYNC, SyncIdx=2 (positions 0 and 1 of the sync word are consumed).
  - `Sym`=4 and PreCnt < PREAMBLE_MIN → IDLE.
  - Any other symbol → IDLE.
- SYNC:
  - Expects 4 at SyncIdx 2..5 and 3 at SyncIdx 6; a match increments SyncIdx.
  - A 3 at SyncIdx 6 → DATA, `SyncDet` pulses the following cycle, SymCnt=0, Acc=0, `WordCnt`=0.
  - Mismatch with `Sym`=3 → PREAMBLE, PreCnt=1.
  - Any other mismatch → IDLE.
- DATA:
  - `Sym` ≤ 4 → Acc = Acc*5 + Sym. Acc is 17 bits wide (max 78124). SymCnt+1.
  - On the 7th symbol (SymCnt=6):
    - If the final value < 65536: `Word`=final[15:0], `WordValid`=1 next cycle, `WordCnt`+1 (saturating).
    - Otherwise: `WordErr`=1 next cycle and `Word` unchanged.
    - In both cases SymCnt=0 and Acc=0. Multiply-add and compare use the same-edge final value.
  - `Sym` ≥ 5 → `CodeErr` pulse next cycle, state IDLE, partial group discarded.
  - Back-to-back words are allowed; `WordValid` can be high at most once per 7 cycles.
- Latency: `WordValid` is asserted in the cycle immediately after the edge that samples the 7th symbol of a group.
- `InBurst` = (state==DATA), registered.
- The pulse outputs (`WordValid`, `WordErr`, `CodeErr`, `SyncDet`) are mutually exclusive by construction.

Decomposition:
- Package `cphy_rx_pkg`:
  - State enum `demap_state_t` {IDLE, PREAMBLE, SYNC, DATA}.
  - Symbol constants SYM_PRE=3'd3 and SYM_SYNC=3'd4.
  - SYMS_PER_WORD=7 and WORD_LIMIT=17'd65536.
  - Sync-word constant array 3,4,4,4,4,4,3.
- Sub-module `cphy_sym_sync_fsm` holds IDLE/PREAMBLE/SYNC detection and emits a DATA-enter strobe. The demap accumulator stays in the top level.

Test Plan:
- Preamble 7×3, then 4,4,4,4,4,3, then data 0,0,0,0,0,0,1 → `SyncDet` pulse one cycle after the final sync 3; `Word`=0x0001 with `WordValid` one cycle after the 7th data symbol; `WordCnt`=1.
- After sync, data 4,0,4,4,1,2,0 followed by 1,0,0,0,0,0,0 → `Word`=0xFFFF then `Word`=0x3D09 on consecutive groups 7 cycles apart; `WordCnt`=2.
- After sync, 4,4,4,4,4,4,4 → `WordErr` pulse, no `WordValid`, `Word` unchanged, `WordCnt` unchanged.
- Preamble of only 5×3 then 4 → state returns to IDLE, no `SyncDet`; the same stream with 7×3 syncs.
- Sync 3,4,4,2 after a valid preamble → IDLE. Sync 3,4,4,3 → PREAMBLE with PreCnt=1. Neither produces `SyncDet`.
- Mid-group, after 3 data symbols:
  - `SymValid` dropped for 1 cycle → IDLE, no word, `WordCnt`=0.
  - Separately, `Sym`=6 → `CodeErr` pulse, IDLE.
  - Separately, `reset`=0 for 1 cycle → all outputs at reset values at the next edge.
